// File: rtl/dcache_lane_arbiter.sv
// Sequences the shared data-cache request port between the two execute lanes (lane 0 first).
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module dcache_lane_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  pause_mem,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_op,
  input  logic [2*ADDR_W-1:0]   req_vaddr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [7:0]            req_wstrb,
  output logic                  port_valid,
  output logic                  port_op,
  output logic [ADDR_W-1:0]     port_vaddr,
  output logic [DATA_W-1:0]     port_wdata,
  output logic [3:0]            port_wstrb,
  input  logic                  port_addr_ok,
  output logic [1:0]            lane_accept,
  output logic                  pause_o,
  output logic [1:0]            issued_o,
  output logic [CNT_W-1:0]      perf_conflict_cnt,
  output logic [CNT_W-1:0]      perf_stall_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    PEND1 = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       sel_lane;
  logic       sel_valid;
  logic       advance;
  logic [1:0] accepted_mask;

  // State register and the issued-lane mask handed to MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      issued_o <= 2'b00;
    end else begin
      state <= state_nxt;
      if (flush) begin
        issued_o <= 2'b00;
      end else if (advance) begin
        issued_o <= accepted_mask;
      end else if (pause_o && !pause_mem) begin
        issued_o <= 2'b00;
      end
    end
  end

  // Lane selection, port mux, acceptance, pause and next state
  always_comb begin
    sel_lane      = 1'b0;
    sel_valid     = 1'b0;
    state_nxt     = state;
    pause_o       = 1'b0;
    port_valid    = 1'b0;
    port_op       = 1'b0;
    port_vaddr    = '0;
    port_wdata    = '0;
    port_wstrb    = 4'h0;
    lane_accept   = 2'b00;
    advance       = 1'b0;
    accepted_mask = 2'b00;

    case (state)
      IDLE: begin
        if (req_valid[0]) begin
          sel_valid = 1'b1;
        end else if (req_valid[1]) begin
          sel_valid = 1'b1;
          sel_lane  = 1'b1;
        end
      end
      PEND1: begin
        sel_valid = req_valid[1];
        sel_lane  = 1'b1;
      end
      default: ;
    endcase

    port_valid = sel_valid && !pause_mem && !flush;

    if (sel_valid) begin
      port_op    = sel_lane ? req_op[1] : req_op[0];
      port_vaddr = sel_lane ? req_vaddr[2*ADDR_W-1:ADDR_W] : req_vaddr[ADDR_W-1:0];
      port_wdata = sel_lane ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      port_wstrb = sel_lane ? req_wstrb[7:4] : req_wstrb[3:0];
    end

    if (port_valid && port_addr_ok) begin
      lane_accept = sel_lane ? 2'b10 : 2'b01;
    end

    // A lane accepted this cycle already counts as done for the pause
    case (state)
      IDLE: begin
        pause_o = (req_valid[0] && !lane_accept[0]) || (req_valid[1] && !lane_accept[1]);
        if (lane_accept[0] && req_valid[1]) state_nxt = PEND1;
      end
      PEND1: begin
        pause_o = !lane_accept[1];
        if (lane_accept[1]) state_nxt = IDLE;
      end
      default: ;
    endcase

    if (flush) begin
      pause_o   = 1'b0;
      state_nxt = IDLE;
    end

    advance       = !pause_o && !pause_mem && !flush;
    accepted_mask = {lane_accept[1], (state == PEND1) || lane_accept[0]};
  end

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] conflict_q;
  logic [CNT_W-1:0] stall_q;

  // Counters are cleared by reset only; flush leaves them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (state == IDLE && state_nxt == PEND1) conflict_q <= conflict_q + CNT_W'(1);
      if (pause_o) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign perf_conflict_cnt = conflict_q;
  assign perf_stall_cnt    = stall_q;
`else
  assign perf_conflict_cnt = '0;
  assign perf_stall_cnt    = '0;
`endif

endmodule
